// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: datapath word and memory-stage FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the word address of the last completed ll
// and reports whether a given address still matches a valid link.
module ll_sc_link
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic [WORD_W-1:0] set_addr,
  input  logic              clr,
  input  logic              snoop,
  input  logic [WORD_W-1:0] snoop_addr,
  input  logic [WORD_W-1:0] chk_addr,
  output logic              match
);

  localparam int unsigned TAG_W = WORD_W - ADDR_LSB;

  logic             link_valid;
  logic [TAG_W-1:0] link_addr;
  logic             snoop_hit;

  always_comb begin
    snoop_hit = snoop & (link_addr == snoop_addr[WORD_W-1:ADDR_LSB]);
    match     = link_valid & (link_addr == chk_addr[WORD_W-1:ADDR_LSB]);
  end

  // A set in the same cycle as a clear/snoop wins: the cache has already
  // ordered the snoop ahead of the ll fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= set_addr[WORD_W-1:ADDR_LSB];
    end else if (clr || snoop_hit) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues dcache requests for loads/stores, stalls until dhit,
// holds the result while the pipeline is frozen, and handles LL/SC.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              adv,
  input  logic              valid_in,
  input  logic              memren_in,
  input  logic              memwen_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic [WORD_W-1:0] aluout_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] port_o_out,
  output logic [WORD_W-1:0] dmemload_out
);

  mem_state_t        state, next_state;
  logic [WORD_W-1:0] data_q;
  logic              sc_ok_q;

  logic memop, active, issue, sc_fail, link_match;
  logic ll_done, sc_done, capture, sc_ok;

  ll_sc_link #(
    .WORD_W   (WORD_W),
    .ADDR_LSB (ADDR_LSB)
  ) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (ll_done),
    .set_addr   (aluout_in),
    .clr        (sc_done),
    .snoop      (snoop_inv),
    .snoop_addr (snoop_addr),
    .chk_addr   (aluout_in),
    .match      (link_match)
  );

  // nRST also gates the request so a reset during WAIT withdraws it at once,
  // not only after the state register has been cleared.
  always_comb begin
    memop   = valid_in & (memren_in | memwen_in);
    active  = (state != DONE);
    issue   = active & memop & nRST & ~flush;
    sc_fail = sc_in & ~link_match;

    dmemREN   = issue & memren_in;
    dmemWEN   = issue & memwen_in & ~sc_fail;
    dmemaddr  = aluout_in;
    dmemstore = store_in;
    mem_stall = issue & ~sc_fail & ~dhit;

    ll_done = issue & ll_in & dhit;
    sc_done = issue & sc_in & (dhit | sc_fail);
    capture = issue & ~sc_fail & dhit & ~adv;

    sc_ok        = active ? (issue & ~sc_fail & dhit) : sc_ok_q;
    port_o_out   = (valid_in & sc_in) ? {{(WORD_W-1){1'b0}}, sc_ok} : aluout_in;
    dmemload_out = active ? dload : data_q;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE, WAIT: begin
          if (!issue || sc_fail) next_state = IDLE;
          else if (dhit)         next_state = adv ? IDLE : DONE;
          else                   next_state = WAIT;
        end
        DONE: begin
          if (adv) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      data_q  <= '0;
      sc_ok_q <= 1'b0;
    end else begin
      state <= next_state;
      if (flush) begin
        data_q  <= '0;
        sc_ok_q <= 1'b0;
      end else if (capture) begin
        data_q  <= dload;
        sc_ok_q <= sc_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// multi-cycle sequences for stalls, DONE hold, LL/SC, flush and reset.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush, adv, valid_in, memren_in, memwen_in, ll_in, sc_in;
  logic [31:0] aluout_in, store_in, dload, snoop_addr;
  logic        dhit, snoop_inv;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore, port_o_out, dmemload_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_stage #(.WORD_W(32), .ADDR_LSB(2)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .adv(adv), .valid_in(valid_in),
    .memren_in(memren_in), .memwen_in(memwen_in), .ll_in(ll_in), .sc_in(sc_in),
    .aluout_in(aluout_in), .store_in(store_in), .dhit(dhit), .dload(dload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .port_o_out(port_o_out), .dmemload_out(dmemload_out)
  );

  typedef struct {
    string       name;
    logic        flush, valid, ren, wen, ll, sc, dhit;
    logic [31:0] alu, store, dload;
    logic        e_ren, e_wen, e_stall;
    logic [31:0] e_port, e_load;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; adv = 1; valid_in = 0; memren_in = 0; memwen_in = 0;
    ll_in = 0; sc_in = 0; aluout_in = '0; store_in = '0; dhit = 0;
    dload = '0; snoop_inv = 0; snoop_addr = '0;
  endtask

  task automatic op(input logic ren, input logic wen, input logic ll, input logic sc,
                    input logic [31:0] alu, input logic [31:0] st);
    valid_in = 1; memren_in = ren; memwen_in = wen; ll_in = ll; sc_in = sc;
    aluout_in = alu; store_in = st;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"add",      0,1,0,0,0,0,0, 32'h1234, 32'h0,    32'h55,   0,0,0, 32'h1234, 32'h55};
    vecs[1] = '{"lw_hit",   0,1,1,0,0,0,1, 32'h100,  32'h0,    32'hCAFE, 1,0,0, 32'h100,  32'hCAFE};
    vecs[2] = '{"sw_hit",   0,1,0,1,0,0,1, 32'h104,  32'hBEEF, 32'h0,    0,1,0, 32'h104,  32'h0};
    vecs[3] = '{"inval_lw", 0,0,1,0,0,0,0, 32'h108,  32'h0,    32'h0,    0,0,0, 32'h108,  32'h0};
    vecs[4] = '{"sc_nolink",0,1,0,1,0,1,0, 32'h200,  32'h77,   32'h0,    0,0,0, 32'h0,    32'h0};
    vecs[5] = '{"flush_lw", 1,1,1,0,0,0,0, 32'h10C,  32'h0,    32'h0,    0,0,0, 32'h10C,  32'h0};

    idle_inputs();
    nRST = 0;
    #12;
    chk("rst_ren",   dmemREN,      0);
    chk("rst_wen",   dmemWEN,      0);
    chk("rst_stall", mem_stall,    0);
    chk("rst_port",  port_o_out,   0);
    chk("rst_load",  dmemload_out, 0);
    nRST = 1;
    next_cycle();

    foreach (vecs[i]) begin
      flush = vecs[i].flush; valid_in = vecs[i].valid; memren_in = vecs[i].ren;
      memwen_in = vecs[i].wen; ll_in = vecs[i].ll; sc_in = vecs[i].sc;
      dhit = vecs[i].dhit; aluout_in = vecs[i].alu; store_in = vecs[i].store;
      dload = vecs[i].dload; adv = 1;
      sample();
      chk({vecs[i].name, "_ren"},   dmemREN,      vecs[i].e_ren);
      chk({vecs[i].name, "_wen"},   dmemWEN,      vecs[i].e_wen);
      chk({vecs[i].name, "_stall"}, mem_stall,    vecs[i].e_stall);
      chk({vecs[i].name, "_port"},  port_o_out,   vecs[i].e_port);
      chk({vecs[i].name, "_load"},  dmemload_out, vecs[i].e_load);
      chk({vecs[i].name, "_addr"},  dmemaddr,     vecs[i].alu);
      chk({vecs[i].name, "_store"}, dmemstore,    vecs[i].store);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // lw with three miss cycles then hit
    op(1, 0, 0, 0, 32'h100, 32'h0);
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("lw3_stall", mem_stall, 1);
      chk("lw3_ren",   dmemREN,   1);
      next_cycle();
    end
    dhit = 1; dload = 32'h1111_2222;
    sample();
    chk("lw3_hit_stall", mem_stall,    0);
    chk("lw3_hit_ren",   dmemREN,      1);
    chk("lw3_hit_load",  dmemload_out, 32'h1111_2222);
    next_cycle();
    idle_inputs();
    next_cycle();

    // lw hits while pipeline frozen: DONE holds data without re-request
    op(1, 0, 0, 0, 32'h300, 32'h0);
    dhit = 1; dload = 32'hABCD; adv = 0;
    sample();
    chk("done_hit_load", dmemload_out, 32'hABCD);
    next_cycle();
    dhit = 0; dload = 32'h0;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("done_ren",   dmemREN,      0);
      chk("done_stall", mem_stall,    0);
      chk("done_load",  dmemload_out, 32'hABCD);
      next_cycle();
    end
    adv = 1;
    sample();
    chk("done_adv_load", dmemload_out, 32'hABCD);
    next_cycle();
    idle_inputs();
    sample();
    chk("done_exit_load", dmemload_out, 32'h0);
    next_cycle();

    // ll then sc succeeds; a repeated sc fails
    op(1, 0, 1, 0, 32'h200, 32'h0); dhit = 1;
    next_cycle();
    op(0, 1, 0, 1, 32'h200, 32'hDEAD); dhit = 0;
    sample();
    chk("sc_wait_wen",   dmemWEN,   1);
    chk("sc_wait_stall", mem_stall, 1);
    next_cycle();
    dhit = 1;
    sample();
    chk("sc_hit_wen",   dmemWEN,    1);
    chk("sc_hit_port",  port_o_out, 1);
    chk("sc_hit_stall", mem_stall,  0);
    chk("sc_store",     dmemstore,  32'hDEAD);
    next_cycle();
    dhit = 0;
    sample();
    chk("sc_again_wen",   dmemWEN,    0);
    chk("sc_again_port",  port_o_out, 0);
    chk("sc_again_stall", mem_stall,  0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // snoop to other word keeps link, snoop to same word clears it
    op(1, 0, 1, 0, 32'h200, 32'h0); dhit = 1;
    next_cycle();
    idle_inputs(); snoop_inv = 1; snoop_addr = 32'h204;
    next_cycle();
    snoop_addr = 32'h200;
    next_cycle();
    snoop_inv = 0;
    op(0, 1, 0, 1, 32'h200, 32'hDEAD);
    sample();
    chk("snp_sc_wen",   dmemWEN,    0);
    chk("snp_sc_port",  port_o_out, 0);
    chk("snp_sc_stall", mem_stall,  0);
    next_cycle();

    op(1, 0, 1, 0, 32'h200, 32'h0); dhit = 1;
    next_cycle();
    idle_inputs(); snoop_inv = 1; snoop_addr = 32'h204;
    next_cycle();
    snoop_inv = 0;
    op(0, 1, 0, 1, 32'h200, 32'h5); dhit = 1;
    sample();
    chk("snp_other_wen",  dmemWEN,    1);
    chk("snp_other_port", port_o_out, 1);
    next_cycle();

    // ll and matching snoop in the same cycle: ll wins
    op(1, 0, 1, 0, 32'h400, 32'h0); dhit = 1;
    snoop_inv = 1; snoop_addr = 32'h400;
    next_cycle();
    snoop_inv = 0;
    op(0, 1, 0, 1, 32'h400, 32'h9); dhit = 1;
    sample();
    chk("ll_snoop_wen", dmemWEN, 1);
    next_cycle();
    idle_inputs();
    next_cycle();

    // sw waiting, then flush
    op(0, 1, 0, 0, 32'h500, 32'h1);
    sample();
    chk("fl_wait_stall", mem_stall, 1);
    next_cycle();
    flush = 1;
    sample();
    chk("fl_wen",   dmemWEN,   0);
    chk("fl_stall", mem_stall, 0);
    next_cycle();
    flush = 0; valid_in = 0;
    sample();
    chk("fl_after_stall", mem_stall, 0);
    chk("fl_after_load",  dmemload_out, 32'h0);
    next_cycle();

    // reset asserted while a load waits
    op(1, 0, 1, 0, 32'h700, 32'h0); dhit = 1;
    next_cycle();
    op(1, 0, 0, 0, 32'h600, 32'h0); dhit = 0;
    sample();
    chk("rw_stall", mem_stall, 1);
    next_cycle();
    nRST = 0;
    #1;
    chk("rw_ren",   dmemREN,   0);
    chk("rw_wen",   dmemWEN,   0);
    chk("rw_stall0", mem_stall, 0);
    sample();
    idle_inputs();
    nRST = 1;
    next_cycle();
    valid_in = 1; aluout_in = 32'h42;
    sample();
    chk("rw_add_stall", mem_stall,  0);
    chk("rw_add_port",  port_o_out, 32'h42);
    next_cycle();
    op(0, 1, 0, 1, 32'h700, 32'h3);
    sample();
    chk("rw_sc_wen",  dmemWEN,    0);
    chk("rw_sc_port", port_o_out, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
